// File: rtl/tsc_dump_receiver.sv
// Host-side receiver for the trigger surround cache serial dump: requests a dump with sbf,
// deserialises the framed stream on sd into a sample memory and waits for the cd completion.
module tsc_dump_receiver #(
    parameter int unsigned NSAMP   = 32,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dump_req,
    output logic                       sbf,
    input  logic                       sd,
    input  logic                       cd,
    input  logic                       trd,
    input  logic [31:0]                trigtm,
    input  logic [$clog2(NSAMP)-1:0]   rd_addr,
    output logic [DW-1:0]              rd_data,
    output logic [31:0]                trig_time,
    output logic                       busy,
    output logic                       rx_done,
    output logic                       rx_err,
    output logic [$clog2(NSAMP):0]     sample_cnt
);

    localparam int unsigned AW = $clog2(NSAMP);
    localparam int unsigned BW = $clog2(DW);
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] REQ        = 3'd1;
    localparam logic [2:0] WAIT_START = 3'd2;
    localparam logic [2:0] SHIFT      = 3'd3;
    localparam logic [2:0] WAIT_CD    = 3'd4;

    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);
    localparam logic [AW:0]   SAMP_LAST = (AW + 1)'(NSAMP - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bidx_q, bidx_d;
    logic [DW-2:0] shreg_q, shreg_d;
    logic [AW:0]   sample_cnt_q, sample_cnt_d;
    logic          rx_done_q, rx_done_d;
    logic          rx_err_q, rx_err_d;
    logic          trd_q;
    logic [31:0]   trig_time_q;
    logic [DW-1:0] rd_data_q;
    logic          mem_we;
    logic [DW-1:0] shift_next;
    logic [DW-1:0] mem [NSAMP];

    // The incoming bit completes the sample, so the write data bypasses the register.
    assign shift_next = {shreg_q, sd};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bidx_d       = bidx_q;
        shreg_d      = shreg_q;
        sample_cnt_d = sample_cnt_q;
        rx_done_d    = rx_done_q;
        rx_err_d     = rx_err_q;
        mem_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d      = REQ;
                    rx_done_d    = 1'b0;
                    rx_err_d     = 1'b0;
                    sample_cnt_d = '0;
                end
            end
            REQ: begin
                state_d = WAIT_START;
                cnt_d   = '0;
            end
            WAIT_START: begin
                bidx_d = '0;
                if (sd) begin
                    state_d = SHIFT;
                end else if (cnt_q == CNT_LAST) begin
                    rx_err_d = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                shreg_d = shift_next[DW-2:0];
                bidx_d  = (bidx_q == BIT_LAST) ? '0 : bidx_q + 1'b1;
                if (bidx_q == BIT_LAST) begin
                    mem_we       = 1'b1;
                    sample_cnt_d = sample_cnt_q + 1'b1;
                    if (sample_cnt_q == SAMP_LAST) begin
                        state_d = WAIT_CD;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_CD: begin
                if (!cd) begin
                    rx_done_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rx_err_d = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bidx_q       <= '0;
            shreg_q      <= '0;
            sample_cnt_q <= '0;
            rx_done_q    <= 1'b0;
            rx_err_q     <= 1'b0;
            trd_q        <= 1'b0;
            trig_time_q  <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bidx_q       <= bidx_d;
            shreg_q      <= shreg_d;
            sample_cnt_q <= sample_cnt_d;
            rx_done_q    <= rx_done_d;
            rx_err_q     <= rx_err_d;
            trd_q        <= trd;
            if (trd && !trd_q) begin
                trig_time_q <= trigtm;
            end
            rd_data_q <= mem[rd_addr];
        end
    end

    // Memory has no reset so a partial dump survives a mid-transfer reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[sample_cnt_q[AW-1:0]] <= shift_next;
        end
    end

    assign sbf        = (state_q == REQ);
    assign busy       = (state_q != IDLE);
    assign rx_done    = rx_done_q;
    assign rx_err     = rx_err_q;
    assign sample_cnt = sample_cnt_q;
    assign trig_time  = trig_time_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_tsc_dump_receiver.sv
// Self-checking bench for tsc_dump_receiver: directed tables, multi-cycle sequences and
// randomized dumps checked against a sample-array / trigger-edge reference model.
module tb_tsc_dump_receiver;

    localparam int NSAMP   = 32;
    localparam int DW      = 8;
    localparam int TIMEOUT = 1024;
    localparam int AW      = 5;
    localparam int NBITS   = NSAMP * DW;

    logic            clk = 1'b0;
    logic            reset, dump_req, sd, cd, trd;
    logic [31:0]     trigtm;
    logic [AW-1:0]   rd_addr;
    logic            sbf, busy, rx_done, rx_err;
    logic [DW-1:0]   rd_data;
    logic [31:0]     trig_time;
    logic [AW:0]     sample_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int sbf_cnt  = 0;

    logic [DW-1:0] tx        [NSAMP];
    logic [DW-1:0] model_mem [NSAMP];
    logic [31:0]   exp_trig;
    logic          rand_trig = 1'b0;
    logic          trd_prev  = 1'b0;

    typedef struct {
        logic        trd;
        logic [31:0] tm;
        logic [31:0] exp;
    } trig_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_vec_t;

    trig_vec_t trig_tab [7];
    rd_vec_t   rd_tab   [4];

    tsc_dump_receiver #(.NSAMP(NSAMP), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .dump_req   (dump_req),
        .sbf        (sbf),
        .sd         (sd),
        .cd         (cd),
        .trd        (trd),
        .trigtm     (trigtm),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .trig_time  (trig_time),
        .busy       (busy),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sbf === 1'b1) sbf_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs changed afterwards are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_trig) begin
            trigtm = $urandom;
            trd    = ($urandom_range(0, 2) == 0);
            if (trd && !trd_prev) exp_trig = trigtm;
        end
        trd_prev = trd;
    endtask

    task automatic rd(input int addr);
        rd_addr = AW'(addr);
        step();
        check("rd_data", 64'(rd_data), 64'(model_mem[addr]));
    endtask

    task automatic do_dump(input int start_delay, input int n_bits, input int early_cd_bit,
                           input int req_bit, input bit rdw);
        int sbf_before;
        sbf_before = sbf_cnt;
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        check("sbf_on_req", 64'(sbf), 64'(1));
        check("busy_on_req", 64'(busy), 64'(1));
        check("cnt_cleared", 64'(sample_cnt), 64'(0));
        check("done_cleared", 64'(rx_done), 64'(0));
        check("err_cleared", 64'(rx_err), 64'(0));
        repeat (start_delay) step();
        sd = 1'b1;
        step();
        for (int k = 0; k < n_bits; k++) begin
            sd       = tx[k/DW][DW-1-(k%DW)];
            cd       = (k != early_cd_bit);
            dump_req = (k == req_bit);
            if (rdw && (k % DW == DW - 1)) rd_addr = AW'(k / DW);
            step();
            if (k % DW == DW - 1) begin
                if (rdw) check("rd_during_write", 64'(rd_data), 64'(model_mem[k/DW]));
                model_mem[k/DW] = tx[k/DW];
                check("sample_cnt_shift", 64'(sample_cnt), 64'(k / DW + 1));
            end
        end
        sd       = 1'b0;
        cd       = 1'b1;
        dump_req = 1'b0;
        check("one_sbf", 64'(sbf_cnt - sbf_before), 64'(1));
    endtask

    task automatic finish_cd(input int delay, input bit with_req);
        int sbf_before;
        check("wait_cd_busy", 64'(busy), 64'(1));
        check("no_early_done", 64'(rx_done), 64'(0));
        repeat (delay) step();
        sbf_before = sbf_cnt;
        cd       = 1'b0;
        dump_req = with_req;
        step();
        cd       = 1'b1;
        dump_req = 1'b0;
        check("rx_done", 64'(rx_done), 64'(1));
        check("rx_err_clear", 64'(rx_err), 64'(0));
        check("idle_after_done", 64'(busy), 64'(0));
        check("sample_cnt_full", 64'(sample_cnt), 64'(NSAMP));
        step();
        check("req_at_exit_ignored", 64'(busy), 64'(0));
        check("no_sbf_at_exit", 64'(sbf_cnt - sbf_before), 64'(0));
    endtask

    // Called on the first cycle of a wait state.
    task automatic wait_timeout();
        repeat (TIMEOUT - 1) step();
        check("busy_before_timeout", 64'(busy), 64'(1));
        check("err_before_timeout", 64'(rx_err), 64'(0));
        step();
        check("busy_after_timeout", 64'(busy), 64'(0));
        check("rx_err_timeout", 64'(rx_err), 64'(1));
        check("done_on_timeout", 64'(rx_done), 64'(0));
    endtask

    initial begin
        trig_tab[0] = '{1'b0, 32'h0000_1111, 32'h0};
        trig_tab[1] = '{1'b1, 32'h0000_1234, 32'h0000_1234};
        trig_tab[2] = '{1'b1, 32'h0000_5555, 32'h0000_1234};
        trig_tab[3] = '{1'b1, 32'h0000_6666, 32'h0000_1234};
        trig_tab[4] = '{1'b0, 32'h0000_7777, 32'h0000_1234};
        trig_tab[5] = '{1'b1, 32'h0000_ABCD, 32'h0000_ABCD};
        trig_tab[6] = '{1'b0, 32'h0000_9999, 32'h0000_ABCD};
        rd_tab[0]   = '{5'h0A, 8'h0A};
        rd_tab[1]   = '{5'h1F, 8'h1F};
        rd_tab[2]   = '{5'h00, 8'h00};
        rd_tab[3]   = '{5'h15, 8'h15};

        reset = 1'b1; dump_req = 1'b0; sd = 1'b0; cd = 1'b1; trd = 1'b0;
        trigtm = '0; rd_addr = '0; exp_trig = '0;
        #23;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_sbf", 64'(sbf), 64'(0));
        check("reset_done", 64'(rx_done), 64'(0));
        check("reset_err", 64'(rx_err), 64'(0));
        check("reset_cnt", 64'(sample_cnt), 64'(0));
        check("reset_trig", 64'(trig_time), 64'(0));
        check("reset_rd", 64'(rd_data), 64'(0));
        reset = 1'b0;
        step();

        foreach (trig_tab[i]) begin
            trd    = trig_tab[i].trd;
            trigtm = trig_tab[i].tm;
            step();
            check("trig_table", 64'(trig_time), 64'(trig_tab[i].exp));
        end
        trd = 1'b0;
        step();

        // Nominal dump with a counting pattern.
        for (int i = 0; i < NSAMP; i++) tx[i] = DW'(i);
        do_dump(3, NBITS, -1, -1, 1'b0);
        finish_cd(5, 1'b0);
        foreach (rd_tab[i]) begin
            rd_addr = rd_tab[i].addr;
            step();
            check("rd_table", 64'(rd_data), 64'(rd_tab[i].exp));
        end

        // Start timeout: sd never rises.
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        check("sbf_start_to", 64'(sbf), 64'(1));
        step();
        wait_timeout();

        // Completion timeout: cd held high after a full frame.
        for (int i = 0; i < NSAMP; i++) tx[i] = DW'($urandom);
        tx[NSAMP-1] = 8'hD5;
        do_dump(2, NBITS, -1, -1, 1'b1);
        wait_timeout();
        rd_addr = 5'h1F;
        step();
        check("mem_kept_after_to", 64'(rd_data), 64'(8'hD5));
        rd(5);

        // Mid-frame dump_req and early cd are ignored; dump_req on the exit edge too.
        for (int i = 0; i < NSAMP; i++) tx[i] = DW'($urandom);
        do_dump(1, NBITS, 100, 150, 1'b1);
        finish_cd(3, 1'b1);
        for (int i = 0; i < 4; i++) rd($urandom_range(0, NSAMP - 1));

        // Reset after ten samples.
        for (int i = 0; i < NSAMP; i++) tx[i] = DW'($urandom);
        do_dump(4, 10 * DW, -1, -1, 1'b0);
        sd = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_cnt", 64'(sample_cnt), 64'(0));
        check("rst_mid_sbf", 64'(sbf), 64'(0));
        check("rst_mid_trig", 64'(trig_time), 64'(0));
        #2;
        reset = 1'b0;
        step();
        for (int i = 0; i <= 10; i++) rd(i);

        // Randomized dumps with random trigger activity.
        exp_trig  = '0;
        rand_trig = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NSAMP; i++) tx[i] = DW'($urandom);
            do_dump($urandom_range(1, 20), NBITS, -1, -1, 1'b1);
            finish_cd($urandom_range(0, 40), 1'b0);
            for (int i = 0; i < 6; i++) rd($urandom_range(0, NSAMP - 1));
        end
        rand_trig = 1'b0;
        step();
        trd = 1'b0;
        step();
        check("trig_random", 64'(trig_time), 64'(exp_trig));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
